// File: rtl/sync_fifo_wr_arbiter.sv
// sync_fifo_wr_arbiter: round-robin arbiter that lets NUM_REQ producers share
// one synchronous FIFO write port. The write strobe and word are registered.
// A local credit counter (level) keeps the FIFO from being overrun.
// Optional feature macro: FIFO_ARB_BURST_EN. When it is defined, the current
// holder keeps priority for up to BURST_LEN consecutive grants.
module sync_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          fifo_w_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    input  logic                          fifo_full,
    input  logic                          fifo_empty,
    input  logic                          fifo_r_en,
    output logic [ADDR_WIDTH:0]           level
);
    localparam int                  PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW-1:0]       LAST     = PW'(NUM_REQ - 1);
    localparam logic [PW:0]         NREQ_W   = (PW+1)'(NUM_REQ);
    localparam logic [ADDR_WIDTH:0] FULL_LVL = (ADDR_WIDTH+1)'(DEPTH);

    // Elaboration-time sanity check on the parameter set.
    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || DEPTH != (1 << ADDR_WIDTH)) begin : g_param_check
        $error("sync_fifo_wr_arbiter: illegal parameter combination");
    end

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] words;
    logic [2*NUM_REQ-1:0]               req_rot;
    logic [PW-1:0]                      ptr, ptr_nxt, win_off, win_idx, win_inc;
    logic [PW:0]                        win_sum, win_wrap;
    logic                               win_found, can_grant, accept, rd;
    logic [ADDR_WIDTH:0]                level_nxt;

    assign words   = req_data;
    // Rotate so that bit 0 is the requester at ptr; the lowest set bit wins.
    assign req_rot = {req, req} >> ptr;

    // A same-cycle read is deliberately not counted as a free slot.
    assign can_grant = rst && (level < FULL_LVL) && !fifo_full;
    assign rd        = fifo_r_en && !fifo_empty;
    assign accept    = can_grant && win_found;

    // Find the first requesting offset from ptr (search from high to low so the lowest wins).
    always_comb begin
        win_found = 1'b0;
        win_off   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_found = 1'b1;
                win_off   = PW'(k);
            end
        end
    end

    // Map the rotated offset back to an absolute requester index.
    always_comb begin
        win_sum  = {1'b0, ptr} + {1'b0, win_off};
        win_wrap = win_sum - NREQ_W;
        win_idx  = (win_sum >= NREQ_W) ? win_wrap[PW-1:0] : win_sum[PW-1:0];
        win_inc  = (win_idx == LAST) ? '0 : win_idx + 1'b1;
    end

    // One-hot grant, forced to zero by reset or lack of credit.
    always_comb begin
        gnt = '0;
        if (accept) gnt[win_idx] = 1'b1;
    end

`ifdef FIFO_ARB_BURST_EN
    localparam int            CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] BL = CW'(BURST_LEN);

    logic [CW-1:0] bcnt, bcnt_run, bcnt_nxt;

    // The holder keeps ptr until its run reaches BURST_LEN. If a different
    // requester wins, the holder dropped req, so a fresh run starts. With no
    // grant (credit stall or idle), the pointer and the count hold.
    always_comb begin
        ptr_nxt  = ptr;
        bcnt_nxt = bcnt;
        bcnt_run = ((win_idx == ptr) ? bcnt : '0) + 1'b1;
        if (accept) begin
            if (bcnt_run >= BL) begin
                ptr_nxt  = win_inc;
                bcnt_nxt = '0;
            end else begin
                ptr_nxt  = win_idx;
                bcnt_nxt = bcnt_run;
            end
        end
    end

    // Burst run-length register.
    always_ff @(posedge clk) begin
        if (!rst) bcnt <= '0;
        else      bcnt <= bcnt_nxt;
    end
`else
    // Plain round-robin: after every grant, move ptr just past the winner.
    always_comb begin
        ptr_nxt = ptr;
        if (accept) ptr_nxt = win_inc;
    end
`endif

    // Credit count: +1 per grant, -1 per real read, unchanged when both occur.
    always_comb begin
        level_nxt = level;
        if (accept && !rd)                       level_nxt = level + 1'b1;
        else if (!accept && rd && level != '0)   level_nxt = level - 1'b1;
    end

    // Registered write port, credit counter and priority pointer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fifo_w_en    <= 1'b0;
            fifo_data_in <= '0;
            level        <= '0;
            ptr          <= '0;
        end else begin
            fifo_w_en <= accept;
            if (accept) fifo_data_in <= words[win_idx];
            level <= level_nxt;
            ptr   <= ptr_nxt;
        end
    end
endmodule
